mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Clock is clk; reset is rst, synchronous and active-high; all state changes on rising clk.
REQ-002: clk  input  1  system clock.
REQ-003: rst  input  1  synchronous active-high reset.
REQ-004: i_request  input  1  instruction fetch request, level, held until i_response.
REQ-005: i_address  input  16  fetch address.
REQ-006: i_rdata  output  16  fetched instruction, registered.
REQ-007: i_response  output  1  one-cycle pulse, i_rdata valid this cycle.
REQ-008: d_request  input  1  data request, level, held until d_response.
REQ-009: d_write  input  1  1=store, 0=load; sampled with d_request.
REQ-010: d_address  input  16  data address.
REQ-011: d_wdata  input  16  store data.
REQ-012: d_rdata  output  16  load data, registered.
REQ-013: d_response  output  1  one-cycle pulse completing data request.
REQ-014: pmem_address  output  16  physical memory address, registered.
REQ-015: pmem_wdata  output  16  physical write data, registered.
REQ-016: pmem_read  output  1  physical read strobe, held until pmem_resp.
REQ-017: pmem_write  output  1  physical write strobe, held until pmem_resp.
REQ-018: pmem_rdata  input  16  physical read data, valid with pmem_resp.
REQ-019: pmem_resp  input  1  physical completion pulse.
REQ-020: Parameter STARVE_LIMIT, default 4, meaning consecutive I-side losses before I-side is forced priority.

Function
REQ-021: FSM states IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D; exactly one transaction outstanding.
REQ-022: IDLE, d_request only -> SERVE_D; i_request only -> SERVE_I; neither -> stay IDLE.
REQ-023: IDLE, both requests -> SERVE_D unless starve_cnt == STARVE_LIMIT, then SERVE_I.
REQ-024: starve_cnt (3 bits) increments on each IDLE grant to D while i_request high; clears on any grant to I; saturates at STARVE_LIMIT.
REQ-025: On grant edge, pmem_address/pmem_wdata latch requester's address/data; requester inputs ignored until its response.
REQ-026: SERVE_I: pmem_read=1, pmem_write=0; SERVE_D: pmem_read=!write, pmem_write=write (latched); strobes 0 in all other states.
REQ-027: SERVE_x with pmem_resp=1 -> RESP_x; strobes drop the cycle after pmem_resp; i_rdata or d_rdata (load only) captures pmem_rdata on that edge.
REQ-028: Store completion leaves d_rdata unchanged.
REQ-029: RESP_x: x_response=1 for exactly one cycle, then IDLE unconditionally; requests not sampled in RESP_x.
REQ-030: Latency: request seen in IDLE at cycle N -> strobe cycle N+1; pmem_resp at cycle M -> response at M+1; earliest next grant sampled at M+2.
REQ-031: pmem_resp outside SERVE_x is ignored; no output changes.
REQ-032: i_response and d_response never high in the same cycle.
REQ-033: Requester dropping request mid-SERVE does not abort; transaction completes and response still pulses.

Reset
REQ-034: rst=1 -> next state IDLE; pmem_read, pmem_write, i_response, d_response, starve_cnt, i_rdata, d_rdata, pmem_address, pmem_wdata all 0.
REQ-035: rst during SERVE_x or RESP_x aborts: strobes and responses 0 from the cycle after the rst edge; no response issued for the aborted request.

Verification
REQ-036: I-only read 0x1000, memory returns 0x5A5A after 3 cycles -> pmem_read 1 for 3 cycles, i_response pulse next cycle with i_rdata=0x5A5A.
REQ-037: D store 0x2002 <- 0xBEEF -> pmem_write=1, pmem_address=0x2002, pmem_wdata=0xBEEF; d_response one pulse; d_rdata unchanged.
REQ-038: i_request and d_request asserted together in IDLE -> D served first, I served immediately after, d_response precedes i_response.
REQ-039: i_request held continuously while d_request reasserted after each response -> I granted on fifth contest (after 4 D wins); starve_cnt returns to 0.
REQ-040: rst asserted in cycle pmem_resp arrives in SERVE_I -> no i_response, i_rdata=0, state IDLE, strobes 0 next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a single-ported physical memory between an instruction-fetch
//   requester (I side) and a load/store requester (D side). Exactly one
//   transaction is outstanding at any time. D normally wins a simultaneous
//   request, but after STARVE_LIMIT consecutive D grants that each left a
//   pending I request waiting, the I side is forced through.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   i_request       : fetch request (level, held until i_response)
//   i_address       : fetch address
//   i_rdata         : fetched word, registered, valid with i_response
//   i_response      : one-cycle completion pulse for the I side
//   d_request       : data request (level, held until d_response)
//   d_write         : 1 = store, 0 = load, sampled with d_request
//   d_address       : data address
//   d_wdata         : store data
//   d_rdata         : load data, registered, untouched by stores
//   d_response      : one-cycle completion pulse for the D side
//   pmem_address    : physical address, registered at grant
//   pmem_wdata      : physical write data, registered at grant
//   pmem_read       : physical read strobe, held until pmem_resp
//   pmem_write      : physical write strobe, held until pmem_resp
//   pmem_rdata      : physical read data, valid with pmem_resp
//   pmem_resp       : physical completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    // Counter is 3 bits wide, so this must stay in 1..7.
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_request,
    input  logic [15:0] i_address,
    output logic [15:0] i_rdata,
    output logic        i_response,
    input  logic        d_request,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_response,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] starve_cnt;
    logic       d_write_q;   // store/load flag captured at the D grant
    logic       starved;
    logic       grant_i;
    logic       grant_d;

    assign starved = (starve_cnt == 3'(STARVE_LIMIT));

    // Next-state decode. Requests are only looked at in IDLE, so a requester
    // that drops its request mid-transaction still gets its response.
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_request && d_request)
                    state_next = starved ? SERVE_I : SERVE_D;
                else if (d_request)
                    state_next = SERVE_D;
                else if (i_request)
                    state_next = SERVE_I;
            end
            SERVE_I: if (pmem_resp) state_next = RESP_I;
            SERVE_D: if (pmem_resp) state_next = RESP_D;
            RESP_I,
            RESP_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_i = (state == IDLE) && (state_next == SERVE_I);
    assign grant_d = (state == IDLE) && (state_next == SERVE_D);

    // Strobes and responses are a pure decode of the state register, so they
    // change only on clock edges and drop together with any reset-forced IDLE.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_response = 1'b0;
        d_response = 1'b0;
        case (state)
            SERVE_I: pmem_read  = 1'b1;
            SERVE_D: begin
                pmem_read  = !d_write_q;
                pmem_write = d_write_q;
            end
            RESP_I:  i_response = 1'b1;
            RESP_D:  d_response = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= 3'd0;
            d_write_q    <= 1'b0;
            pmem_address <= 16'h0000;
            pmem_wdata   <= 16'h0000;
            i_rdata      <= 16'h0000;
            d_rdata      <= 16'h0000;
        end else begin
            state <= state_next;

            if (grant_i) begin
                starve_cnt   <= 3'd0;
                pmem_address <= i_address;
            end

            if (grant_d) begin
                pmem_address <= d_address;
                pmem_wdata   <= d_wdata;
                d_write_q    <= d_write;
                // Only a D win over a waiting I counts as an I loss.
                if (i_request && !starved)
                    starve_cnt <= starve_cnt + 3'd1;
            end

            // Read data is captured on the completing edge only; a stray
            // pmem_resp in any other state is ignored.
            if (state == SERVE_I && pmem_resp)
                i_rdata <= pmem_rdata;
            if (state == SERVE_D && pmem_resp && !d_write_q)
                d_rdata <= pmem_rdata;
        end
    end

endmodule
